// File: rtl/address_receiver.sv
// Address link receiver: rebuilds an ADDR_W-bit address from BUS_W-bit chunks
// (LSB chunk first) and hands it to the consumer with a valid/ready handshake.
// Flags truncated transfers (abort) and chunks arriving while an address is
// still held (overrun).
module address_receiver #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BUS_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BUS_W-1:0]  addr_bus,
    input  logic              send_addr,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    output logic              abort,
    output logic              overrun
);

    localparam int unsigned NUM_CHUNKS = (ADDR_W + BUS_W - 1) / BUS_W;
    localparam int unsigned PAD_W      = NUM_CHUNKS * BUS_W;
    localparam int unsigned CNT_W      = $clog2(NUM_CHUNKS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_HOLD = 2'd2,
        S_SKIP = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_discard;

    logic [PAD_W-1:0]   w_bus_wide;
    logic [31:0]        w_shamt;
    logic [ADDR_W-1:0]  w_first;
    logic [ADDR_W-1:0]  w_merged;

    // Place the incoming chunk at its slot; bits of the final chunk that land
    // above ADDR_W fall off in the truncating cast, so junk there is ignored.
    assign w_bus_wide = PAD_W'(addr_bus);
    assign w_shamt    = 32'(r_count) * 32'(BUS_W);
    assign w_first    = ADDR_W'(w_bus_wide);
    assign w_merged   = addr_out | ADDR_W'(w_bus_wide << w_shamt);

    // Receive FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_discard  <= 1'b0;
            addr_out   <= '0;
            addr_valid <= 1'b0;
            abort      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            abort   <= 1'b0;
            overrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (send_addr) begin
                        addr_out <= w_first;
                        r_count  <= CNT_W'(1);
                        if (NUM_CHUNKS == 1) begin
                            r_state    <= S_HOLD;
                            addr_valid <= 1'b1;
                        end else begin
                            r_state <= S_RECV;
                        end
                    end
                end
                S_RECV: begin
                    if (send_addr) begin
                        addr_out <= w_merged;
                        r_count  <= r_count + CNT_W'(1);
                        if (r_count == CNT_W'(NUM_CHUNKS - 1)) begin
                            r_state    <= S_HOLD;
                            addr_valid <= 1'b1;
                        end
                    end else begin
                        abort    <= 1'b1;
                        addr_out <= '0;
                        r_count  <= '0;
                        r_state  <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (addr_ready) begin
                        // Handshake completes; shift register cleared on exit.
                        addr_valid <= 1'b0;
                        addr_out   <= '0;
                        r_count    <= '0;
                        r_discard  <= 1'b0;
                        if (!send_addr) begin
                            r_state <= S_IDLE;
                        end else if (r_discard) begin
                            overrun <= 1'b1;
                            r_state <= S_SKIP;
                        end else begin
                            // Back-to-back: this chunk starts the next address.
                            addr_out <= w_first;
                            r_count  <= CNT_W'(1);
                            if (NUM_CHUNKS == 1) begin
                                addr_valid <= 1'b1;
                            end else begin
                                r_state <= S_RECV;
                            end
                        end
                    end else if (send_addr) begin
                        overrun   <= 1'b1;
                        r_discard <= 1'b1;
                    end else begin
                        r_discard <= 1'b0;
                    end
                end
                S_SKIP: begin
                    if (!send_addr) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_address_receiver.sv
// Directed bench for address_receiver: 32/8 instance plus a 12/5 instance for
// the partial final chunk case.
module tb_address_receiver;

    logic        clk;
    logic        reset;

    logic [7:0]  addr_bus;
    logic        send_addr;
    logic        addr_ready;
    logic [31:0] addr_out;
    logic        addr_valid;
    logic        abort;
    logic        overrun;

    logic [4:0]  s_bus;
    logic        s_send;
    logic        s_ready;
    logic [11:0] s_out;
    logic        s_valid;
    logic        s_abort;
    logic        s_overrun;

    int n_checks;
    int n_errors;
    int ab_cnt;
    int ov_cnt;

    address_receiver #(.ADDR_W(32), .BUS_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr_bus   (addr_bus),
        .send_addr  (send_addr),
        .addr_ready (addr_ready),
        .addr_out   (addr_out),
        .addr_valid (addr_valid),
        .abort      (abort),
        .overrun    (overrun)
    );

    address_receiver #(.ADDR_W(12), .BUS_W(5)) dut_s (
        .clk        (clk),
        .reset      (reset),
        .addr_bus   (s_bus),
        .send_addr  (s_send),
        .addr_ready (s_ready),
        .addr_out   (s_out),
        .addr_valid (s_valid),
        .abort      (s_abort),
        .overrun    (s_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (abort)   ab_cnt++;
        if (overrun) ov_cnt++;
        if (abort && overrun) check("abort_overrun_excl", 32'(abort & overrun), 32'd0);
    endtask

    task automatic send_chunk(input logic [7:0] b);
        addr_bus  = b;
        send_addr = 1'b1;
        tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_chunk(w[i*8 +: 8]);
        end
    endtask

    task automatic idle();
        send_addr = 1'b0;
        addr_bus  = 8'h00;
        tick();
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        ab_cnt     = 0;
        ov_cnt     = 0;
        reset      = 1'b1;
        addr_bus   = 8'h00;
        send_addr  = 1'b0;
        addr_ready = 1'b0;
        s_bus      = 5'h00;
        s_send     = 1'b0;
        s_ready    = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_addr_out",  addr_out,          32'h0);
        check("rst_valid",     32'(addr_valid),   32'd0);
        check("rst_abort",     32'(abort),        32'd0);
        check("rst_overrun",   32'(overrun),      32'd0);

        // Basic reassembly with ready held high
        addr_ready = 1'b1;
        send_chunk(8'hEF);
        check("basic_valid_c0", 32'(addr_valid), 32'd0);
        send_chunk(8'hBE);
        check("basic_valid_c1", 32'(addr_valid), 32'd0);
        send_chunk(8'hAD);
        check("basic_valid_c2", 32'(addr_valid), 32'd0);
        send_chunk(8'hDE);
        check("basic_valid",    32'(addr_valid), 32'd1);
        check("basic_addr",     addr_out,        32'hDEADBEEF);
        idle();
        check("basic_valid_drop", 32'(addr_valid), 32'd0);
        check("basic_no_abort",   32'(ab_cnt),     32'd0);
        check("basic_no_overrun", 32'(ov_cnt),     32'd0);

        // Partial final chunk on the 12/5 instance
        s_ready = 1'b1;
        s_send  = 1'b1;
        s_bus   = 5'h1C; tick();
        s_bus   = 5'h15; tick();
        check("part_valid_early", 32'(s_valid), 32'd0);
        s_bus   = 5'h1E; tick();
        check("part_valid", 32'(s_valid), 32'd1);
        check("part_addr",  32'(s_out),   32'h0000_0ABC);
        s_send  = 1'b0;
        s_bus   = 5'h00;
        tick();
        check("part_valid_drop", 32'(s_valid), 32'd0);
        check("part_no_flags",   32'({s_abort, s_overrun}), 32'd0);

        // Abort after two chunks
        ab_cnt = 0;
        send_chunk(8'h11);
        send_chunk(8'h22);
        idle();
        check("abort_pulse",    32'(abort),      32'd1);
        check("abort_valid",    32'(addr_valid), 32'd0);
        check("abort_addr_clr", addr_out,        32'h0);
        idle();
        check("abort_one_cycle", 32'(abort), 32'd0);
        send_word(32'h04030201);
        check("abort_next_valid", 32'(addr_valid), 32'd1);
        check("abort_next_addr",  addr_out,        32'h04030201);
        idle();
        check("abort_count", 32'(ab_cnt), 32'd1);

        // Overrun while address is unconsumed
        ov_cnt     = 0;
        addr_ready = 1'b0;
        send_word(32'h12345678);
        check("ovr_valid", 32'(addr_valid), 32'd1);
        check("ovr_addr",  addr_out,        32'h12345678);
        idle();
        check("ovr_hold_valid", 32'(addr_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send_chunk(8'hA0 + 8'(i));
            check("ovr_pulse",     32'(overrun),    32'd1);
            check("ovr_addr_keep", addr_out,        32'h12345678);
            check("ovr_valid_keep",32'(addr_valid), 32'd1);
        end
        idle();
        check("ovr_pulse_end", 32'(overrun),    32'd0);
        check("ovr_still_val", 32'(addr_valid), 32'd1);
        addr_ready = 1'b1;
        idle();
        check("ovr_valid_drop", 32'(addr_valid), 32'd0);
        send_word(32'hCAFEF00D);
        check("ovr_next_valid", 32'(addr_valid), 32'd1);
        check("ovr_next_addr",  addr_out,        32'hCAFEF00D);
        idle();
        check("ovr_count", 32'(ov_cnt), 32'd4);

        // Back-to-back with one idle cycle, then with no gap
        ab_cnt = 0;
        ov_cnt = 0;
        send_word(32'hAABBCCDD);
        check("b2b_valid1", 32'(addr_valid), 32'd1);
        check("b2b_addr1",  addr_out,        32'hAABBCCDD);
        idle();
        check("b2b_gap_valid", 32'(addr_valid), 32'd0);
        send_word(32'h01020304);
        check("b2b_valid2", 32'(addr_valid), 32'd1);
        check("b2b_addr2",  addr_out,        32'h01020304);
        idle();
        send_word(32'h44332211);
        check("b2b_nogap_addr1", addr_out, 32'h44332211);
        send_chunk(8'h55);
        check("b2b_nogap_drop", 32'(addr_valid), 32'd0);
        send_chunk(8'h66);
        send_chunk(8'h77);
        send_chunk(8'h88);
        check("b2b_nogap_valid2", 32'(addr_valid), 32'd1);
        check("b2b_nogap_addr2",  addr_out,        32'h88776655);
        idle();
        check("b2b_no_flags", 32'(ab_cnt + ov_cnt), 32'd0);

        // Reset mid-transfer
        send_chunk(8'h04);
        send_chunk(8'h03);
        reset     = 1'b1;
        send_addr = 1'b0;
        tick();
        reset = 1'b0;
        check("mrst_addr",    addr_out,                          32'h0);
        check("mrst_flags",   32'({addr_valid, abort, overrun}), 32'd0);
        idle();
        check("mrst_no_abort", 32'(abort), 32'd0);
        send_word(32'h01020304);
        check("mrst_valid", 32'(addr_valid), 32'd1);
        check("mrst_addr2", addr_out,        32'h01020304);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
